// File: rtl/mcast_pkg.sv
// Shared constants and types for the multicast route-compute fork sequencer.
package mcast_pkg;

    localparam int unsigned DATASIZE = 30;
    localparam int unsigned NCOPY    = 3;
    localparam int unsigned DIRW     = 5;
    localparam int unsigned WAIT_W   = 8;

    localparam int unsigned DST_HI = 24;
    localparam int unsigned DST_LO = 9;
    localparam int unsigned DST_W  = DST_HI - DST_LO + 1;

    localparam logic [DIRW-1:0] DIR_N = 5'b00001;
    localparam logic [DIRW-1:0] DIR_E = 5'b00010;
    localparam logic [DIRW-1:0] DIR_S = 5'b00100;
    localparam logic [DIRW-1:0] DIR_W = 5'b01000;
    localparam logic [DIRW-1:0] DIR_L = 5'b10000;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } fork_state_e;

endpackage

// File: rtl/rc_mcast_fork_ctrl_if.sv
// Input-buffer / RC / switch-allocator signal bundle of one router input port.
interface rc_mcast_fork_ctrl_if #(
    parameter int unsigned DATASIZE = 30,
    parameter int unsigned NCOPY    = 3,
    parameter int unsigned DIRW     = 5,
    parameter int unsigned WAIT_W   = 8
);
    logic                      in_valid;
    logic                      in_pop;
    logic                      rc_ready;
    logic                      rc_valid;
    logic [NCOPY*DATASIZE-1:0] br_data;
    logic [NCOPY*DIRW-1:0]     br_dir;
    logic [NCOPY-1:0]          req_valid;
    logic [NCOPY*DIRW-1:0]     req_dir;
    logic [NCOPY*DATASIZE-1:0] req_data;
    logic [NCOPY-1:0]          grant;
    logic                      busy;
    logic                      stall;
    logic [WAIT_W-1:0]         drop_cnt;

    modport master (
        output in_valid, br_data, br_dir, grant,
        input  in_pop, rc_ready, rc_valid, req_valid, req_dir, req_data,
               busy, stall, drop_cnt
    );

    modport slave (
        input  in_valid, br_data, br_dir, grant,
        output in_pop, rc_ready, rc_valid, req_valid, req_dir, req_data,
               busy, stall, drop_cnt
    );
endinterface

// File: rtl/mcast_copy_tracker.sv
// Pending-copy mask with live-copy detection and the "last grant" predicate.
module mcast_copy_tracker #(
    parameter int unsigned NCOPY = 3,
    parameter int unsigned DIRW  = 5,
    parameter int unsigned DST_W = 16
) (
    input  logic                        rc_clk,
    input  logic                        rst_n,
    input  logic                        load_i,
    input  logic [NCOPY-1:0]            grant_i,
    input  logic [NCOPY-1:0][DST_W-1:0] dst_i,
    input  logic [NCOPY-1:0][DIRW-1:0]  dir_i,
    output logic [NCOPY-1:0]            pending_o,
    output logic [NCOPY-1:0]            live_o,
    output logic                        last_o
);
    logic [NCOPY-1:0] pending_q, pending_d;

    always_comb begin
        live_o = '0;
        for (int i = 0; i < int'(NCOPY); i++) begin
            live_o[i] = (|dir_i[i]) && (|dst_i[i]);
        end
    end

    // On the load cycle the fresh live mask decides whether the flit is already done.
    always_comb begin
        pending_d = load_i ? live_o : (pending_q & ~grant_i);
        last_o    = load_i ? (live_o == '0) : ((pending_q & ~grant_i) == '0);
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
endmodule

// File: rtl/rc_mcast_fork_ctrl.sv
// Multicast fork sequencer: pops a flit, loads RC, issues live copies until all granted.
module rc_mcast_fork_ctrl
    import mcast_pkg::*;
#(
    parameter int unsigned P_DATASIZE = DATASIZE,
    parameter int unsigned P_NCOPY    = NCOPY,
    parameter int unsigned P_DIRW     = DIRW,
    parameter int unsigned P_WAIT_W   = WAIT_W
) (
    input logic                  rc_clk,
    input logic                  rst_n,
    rc_mcast_fork_ctrl_if.slave  bus
);
    fork_state_e state_q, state_d;
    logic                  load_pend_q, load_pend_d;
    logic [P_WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [P_WAIT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [P_NCOPY-1:0]    pending, live, req_valid_c;
    logic                  last;
    logic                  rc_ready_c;
    logic [P_NCOPY-1:0][DST_W-1:0]  dst_list;
    logic [P_NCOPY-1:0][P_DIRW-1:0] dir_list;

    for (genvar g = 0; g < int'(P_NCOPY); g++) begin : g_copy
        assign dst_list[g] = bus.br_data[g*P_DATASIZE + DST_LO +: DST_W];
        assign dir_list[g] = bus.br_dir[g*P_DIRW +: P_DIRW];
        assign bus.req_dir[g*P_DIRW +: P_DIRW] = req_valid_c[g] ? dir_list[g] : '0;
    end

    mcast_copy_tracker #(
        .NCOPY (P_NCOPY),
        .DIRW  (P_DIRW),
        .DST_W (DST_W)
    ) u_tracker (
        .rc_clk    (rc_clk),
        .rst_n     (rst_n),
        .load_i    (load_pend_q),
        .grant_i   (bus.grant),
        .dst_i     (dst_list),
        .dir_i     (dir_list),
        .pending_o (pending),
        .live_o    (live),
        .last_o    (last)
    );

    always_comb begin
        state_d     = state_q;
        load_pend_d = 1'b0;
        rc_ready_c  = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rc_ready_c  = 1'b1;
                    load_pend_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (load_pend_q && (live == '0) && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + P_WAIT_W'(1);
                end
                if (|(pending & bus.grant)) begin
                    wait_cnt_d = '0;
                end else if ((pending != '0) && (wait_cnt_q != '1)) begin
                    wait_cnt_d = wait_cnt_q + P_WAIT_W'(1);
                end
                if (last) begin
                    if (bus.in_valid) begin
                        rc_ready_c  = 1'b1;
                        load_pend_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rc_ready_c) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_pend_q <= 1'b0;
            wait_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_pend_q <= load_pend_d;
            wait_cnt_q  <= wait_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Pending is a register; masking only hides it during the load cycle.
    assign req_valid_c   = ((state_q == ISSUE) && !load_pend_q) ? pending : '0;

    assign bus.rc_ready  = rc_ready_c & rst_n;
    assign bus.in_pop    = rc_ready_c & rst_n;
    assign bus.rc_valid  = rc_ready_c & rst_n;
    assign bus.req_valid = req_valid_c;
    assign bus.req_data  = bus.br_data;
    assign bus.busy      = (state_q == ISSUE);
    assign bus.stall     = (wait_cnt_q == '1);
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_rc_mcast_fork_ctrl.sv
// Directed bench for rc_mcast_fork_ctrl with hand-computed expectations.
module tb_rc_mcast_fork_ctrl;
    import mcast_pkg::*;

    logic rc_clk;
    logic rst_n;
    int   err_cnt;
    int   chk_cnt;

    rc_mcast_fork_ctrl_if #(
        .DATASIZE (DATASIZE), .NCOPY (NCOPY), .DIRW (DIRW), .WAIT_W (WAIT_W)
    ) bus ();

    rc_mcast_fork_ctrl dut (
        .rc_clk (rc_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial rc_clk = 1'b0;
    always #5 rc_clk = ~rc_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic cyc();
        @(posedge rc_clk);
        #1;
    endtask

    function automatic logic [29:0] mk(input logic [15:0] dst, input logic flag);
        return {5'b0, dst, 8'h00, flag};
    endfunction

    task automatic set_br(input logic [29:0] d2, input logic [29:0] d1, input logic [29:0] d0,
                          input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0);
        bus.br_data = {d2, d1, d0};
        bus.br_dir  = {r2, r1, r0};
    endtask

    logic [89:0] exp_data;

    initial begin
        err_cnt      = 0;
        chk_cnt      = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.grant    = '0;
        set_br(mk(16'h0201, 1'b1), mk(16'h0201, 1'b1), mk(16'h0201, 1'b1), DIR_L, DIR_E, DIR_N);

        // Reset state, with in_valid high to expose the rc_ready gating
        #12;
        chk("rst_rc_ready", bus.rc_ready, 1'b0);
        chk("rst_in_pop", bus.in_pop, 1'b0);
        chk("rst_rc_valid", bus.rc_valid, 1'b0);
        chk("rst_req_valid", bus.req_valid, 3'b000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_drop_cnt", bus.drop_cnt, 8'd0);
        bus.in_valid = 1'b0;
        #4 rst_n = 1'b1;

        // 1: single flit, all copies live, all granted at once
        cyc(); bus.in_valid = 1'b1; #1;
        chk("t1_rc_ready_N", bus.rc_ready, 1'b1);
        chk("t1_in_pop_N", bus.in_pop, 1'b1);
        chk("t1_rc_valid_N", bus.rc_valid, 1'b1);
        chk("t1_busy_N", bus.busy, 1'b0);
        cyc(); bus.in_valid = 1'b0; #1;
        chk("t1_busy_N1", bus.busy, 1'b1);
        chk("t1_req_N1", bus.req_valid, 3'b000);
        chk("t1_rc_ready_N1", bus.rc_ready, 1'b0);
        cyc(); bus.grant = 3'b111; #1;
        exp_data = {mk(16'h0201, 1'b1), mk(16'h0201, 1'b1), mk(16'h0201, 1'b1)};
        chk("t1_req_N2", bus.req_valid, 3'b111);
        chk("t1_req_dir_N2", bus.req_dir, {DIR_L, DIR_E, DIR_N});
        chk("t1_req_data_N2", bus.req_data, exp_data);
        cyc(); bus.grant = 3'b000; #1;
        chk("t1_req_N3", bus.req_valid, 3'b000);
        chk("t1_busy_N3", bus.busy, 1'b0);
        chk("t1_drop_N3", bus.drop_cnt, 8'd0);

        // 2: staggered grants, in_valid held high, back-to-back reload
        cyc(); bus.in_valid = 1'b1; #1;
        chk("t2_rc_ready_N", bus.rc_ready, 1'b1);
        cyc(); #1;
        chk("t2_rc_ready_N1", bus.rc_ready, 1'b0);
        chk("t2_req_N1", bus.req_valid, 3'b000);
        cyc(); bus.grant = 3'b001; #1;
        chk("t2_req_N2", bus.req_valid, 3'b111);
        chk("t2_rc_ready_N2", bus.rc_ready, 1'b0);
        cyc(); bus.grant = 3'b000; #1;
        chk("t2_req_N3", bus.req_valid, 3'b110);
        cyc(); bus.grant = 3'b100; #1;
        chk("t2_req_N4", bus.req_valid, 3'b110);
        chk("t2_rc_ready_N4", bus.rc_ready, 1'b0);
        cyc(); bus.grant = 3'b000; #1;
        chk("t2_req_N5", bus.req_valid, 3'b010);
        cyc(); #1;
        chk("t2_rc_ready_N6", bus.rc_ready, 1'b0);
        cyc(); bus.grant = 3'b010; #1;
        chk("t2_rc_ready_N7", bus.rc_ready, 1'b1);
        cyc(); bus.grant = 3'b000; bus.in_valid = 1'b0;
        set_br(mk(16'h0003, 1'b0), mk(16'h0003, 1'b0), mk(16'h0003, 1'b0), 5'b0, DIR_W, DIR_S);
        #1;
        chk("t2_req_N8", bus.req_valid, 3'b000);
        chk("t2_busy_N8", bus.busy, 1'b1);
        cyc(); bus.grant = 3'b011; #1;
        chk("t2_req_N9", bus.req_valid, 3'b011);
        chk("t2_req_dir_N9", bus.req_dir, {5'b0, DIR_W, DIR_S});
        cyc(); bus.grant = 3'b000; #1;
        chk("t2_busy_N10", bus.busy, 1'b0);

        // 3: empty destination list is dropped
        set_br(mk(16'h0000, 1'b1), mk(16'h0000, 1'b1), mk(16'h0000, 1'b1), DIR_L, DIR_E, DIR_N);
        cyc(); bus.in_valid = 1'b1; #1;
        chk("t3_rc_ready_N", bus.rc_ready, 1'b1);
        cyc(); bus.in_valid = 1'b0; #1;
        chk("t3_req_N1", bus.req_valid, 3'b000);
        chk("t3_drop_N1", bus.drop_cnt, 8'd0);
        cyc(); #1;
        chk("t3_req_N2", bus.req_valid, 3'b000);
        chk("t3_drop_N2", bus.drop_cnt, 8'd1);
        chk("t3_busy_N2", bus.busy, 1'b0);

        // 4: only copy 2 live, grants on other bits ignored
        set_br(mk(16'h0005, 1'b0), 30'h0, 30'h0, DIR_S, DIR_E, DIR_N);
        cyc(); bus.in_valid = 1'b1; #1;
        cyc(); bus.in_valid = 1'b0; #1;
        cyc(); bus.grant = 3'b011; #1;
        chk("t4_req_N2", bus.req_valid, 3'b100);
        chk("t4_req_dir_N2", bus.req_dir, {DIR_S, 5'b0, 5'b0});
        cyc(); bus.grant = 3'b000; #1;
        chk("t4_req_N3", bus.req_valid, 3'b100);
        chk("t4_busy_N3", bus.busy, 1'b1);
        cyc(); bus.grant = 3'b100; #1;
        cyc(); bus.grant = 3'b000; #1;
        chk("t4_busy_N5", bus.busy, 1'b0);
        chk("t4_drop_N5", bus.drop_cnt, 8'd1);

        // 5: no grants for a long time saturates the wait counter
        set_br(mk(16'h0201, 1'b1), mk(16'h0201, 1'b1), mk(16'h0201, 1'b1), DIR_L, DIR_E, DIR_N);
        cyc(); bus.in_valid = 1'b1; #1;
        cyc(); bus.in_valid = 1'b0; #1;
        for (int k = 2; k <= 256; k++) cyc();
        #1;
        chk("t5_stall_N256", bus.stall, 1'b0);
        cyc(); #1;
        chk("t5_stall_N257", bus.stall, 1'b1);
        for (int k = 258; k <= 301; k++) cyc();
        #1;
        chk("t5_stall_N301", bus.stall, 1'b1);
        chk("t5_req_N301", bus.req_valid, 3'b111);
        cyc(); bus.grant = 3'b001; #1;
        chk("t5_stall_N302", bus.stall, 1'b1);
        cyc(); bus.grant = 3'b000; #1;
        chk("t5_stall_N303", bus.stall, 1'b0);
        chk("t5_req_N303", bus.req_valid, 3'b110);
        cyc(); bus.grant = 3'b110; #1;
        cyc(); bus.grant = 3'b000; #1;
        chk("t5_busy_N305", bus.busy, 1'b0);

        // 6: reset asserted mid-issue with copies 1 and 2 still pending
        cyc(); bus.in_valid = 1'b1; #1;
        cyc(); bus.in_valid = 1'b0; #1;
        cyc(); bus.grant = 3'b001; #1;
        cyc(); bus.grant = 3'b000; #1;
        chk("t6_req_pre", bus.req_valid, 3'b110);
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_req_rst", bus.req_valid, 3'b000);
        chk("t6_rc_ready_rst", bus.rc_ready, 1'b0);
        chk("t6_busy_rst", bus.busy, 1'b0);
        chk("t6_drop_rst", bus.drop_cnt, 8'd0);
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b1;
        cyc(); #1;
        chk("t6_busy_post", bus.busy, 1'b0);
        chk("t6_req_post", bus.req_valid, 3'b000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
